// File: rtl/pdm_ddr_deserializer.sv
// pdm_ddr_deserializer: PDM clock generator and DDR microphone deserializer with valid/ready output.
// Optional feature: define PDM_DESER_OVR_CNT_EN to add the 8-bit saturating dropped-frame counter ovr_count.
// rst is asynchronous and active-low.
module pdm_ddr_deserializer #(
    parameter int N_LINES    = 8,
    parameter int DIV        = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [N_LINES-1:0]              ddr_data,
    output logic                            pdm_clk_o,
    output logic [N_LINES*FRAME_BITS-1:0]   out_data_0,
    output logic [N_LINES*FRAME_BITS-1:0]   out_data_1,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            overrun,
    input  logic                            ovr_clr
`ifdef PDM_DESER_OVR_CNT_EN
    ,
    output logic [7:0]                      ovr_count
`endif
);
    localparam int PW = $clog2(2 * DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [PW-1:0] PH_A   = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_B   = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PH_DIV = PW'(DIV);
    localparam logic [BW-1:0] BC_L   = BW'(FRAME_BITS - 1);

    logic [N_LINES-1:0]                   r_sync1;
    logic [N_LINES-1:0]                   r_sync2;
    logic [PW-1:0]                        r_ph;
    logic [BW-1:0]                        r_bc;
    logic                                 r_pdm;
    logic [N_LINES-1:0]                   r_stage;
    logic [N_LINES-1:0][FRAME_BITS-1:0]   r_sh_a;
    logic [N_LINES-1:0][FRAME_BITS-1:0]   r_sh_b;
    logic [N_LINES-1:0][FRAME_BITS-1:0]   r_out_a;
    logic [N_LINES-1:0][FRAME_BITS-1:0]   r_out_b;
    logic                                 r_valid;
    logic                                 r_ovr;

    logic [PW-1:0]                        w_ph_nxt;
    logic                                 w_cap;
    logic                                 w_shift;
    logic                                 w_frame;
    logic                                 w_load;
    logic                                 w_drop;
    logic [N_LINES-1:0][FRAME_BITS-1:0]   w_word_a;
    logic [N_LINES-1:0][FRAME_BITS-1:0]   w_word_b;

    assign w_ph_nxt = en ? ((r_ph == PH_B) ? '0 : r_ph + PW'(1)) : '0;
    assign w_cap    = en && (r_ph == PH_A);
    assign w_shift  = en && (r_ph == PH_B);
    assign w_frame  = w_shift && (r_bc == BC_L);
    assign w_load   = w_frame && (!r_valid || out_ready);
    assign w_drop   = w_frame && r_valid && !out_ready;

    assign pdm_clk_o  = r_pdm;
    assign out_data_0 = r_out_a;
    assign out_data_1 = r_out_b;
    assign out_valid  = r_valid;
    assign overrun    = r_ovr;

    // Two-flop synchronizer per line; everything downstream samples r_sync2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ddr_data;
            r_sync2 <= r_sync1;
        end
    end

    // Phase counter and the PDM clock flop, which looks one phase ahead so the pin is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ph  <= '0;
            r_pdm <= 1'b0;
        end else begin
            r_ph  <= w_ph_nxt;
            r_pdm <= en && (w_ph_nxt < PH_DIV);
        end
    end

    // Next shift-register contents: oldest bit moves toward the MSB, newest enters at bit 0.
    always_comb begin
        w_word_a = '0;
        w_word_b = '0;
        for (int i = 0; i < N_LINES; i++) begin
            w_word_a[i] = {r_sh_a[i][FRAME_BITS-2:0], r_stage[i]};
            w_word_b[i] = {r_sh_b[i][FRAME_BITS-2:0], r_sync2[i]};
        end
    end

    // Channel-A staging, per-line shift registers and bit counter; cleared while disabled to drop partial frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage <= '0;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_bc    <= '0;
        end else if (!en) begin
            r_stage <= '0;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_bc    <= '0;
        end else begin
            if (w_cap)
                r_stage <= r_sync2;
            if (w_shift) begin
                r_sh_a <= w_word_a;
                r_sh_b <= w_word_b;
                r_bc   <= (r_bc == BC_L) ? '0 : r_bc + BW'(1);
            end
        end
    end

    // Output holding register with valid/ready; a completed frame replaces the held one only if it is free or leaving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_a <= '0;
            r_out_b <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_out_a <= w_word_a;
            r_out_b <= w_word_b;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ovr <= 1'b0;
        else
            r_ovr <= w_drop ? 1'b1 : (ovr_clr ? 1'b0 : r_ovr);
    end

`ifdef PDM_DESER_OVR_CNT_EN
    logic [7:0] r_ovr_cnt;

    assign ovr_count = r_ovr_cnt;

    // Saturating dropped-frame counter; a drop coinciding with a clear leaves a count of one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ovr_cnt <= 8'd0;
        else
            r_ovr_cnt <= w_drop ? (ovr_clr ? 8'd1 : ((r_ovr_cnt == 8'hFF) ? 8'hFF : r_ovr_cnt + 8'd1))
                                : (ovr_clr ? 8'd0 : r_ovr_cnt);
    end
`else
    // Without the counter, drops are recorded only by the sticky overrun flag.
`endif

endmodule

// File: tb/tb_pdm_ddr_deserializer.sv
// tb_pdm_ddr_deserializer: directed bench with a cycle-count model of frames, handshake and overrun.
module tb_pdm_ddr_deserializer;
    localparam int NL  = 2;
    localparam int DIV = 4;
    localparam int FB  = 8;
    localparam int P   = 2 * DIV;
    localparam int F   = P * FB;
    localparam int W   = NL * FB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          out_ready = 1'b1;
    logic          ovr_clr = 1'b0;
    logic [NL-1:0] ddr_data = '0;
    logic          pdm_clk_o;
    logic [W-1:0]  out_data_0;
    logic [W-1:0]  out_data_1;
    logic          out_valid;
    logic          overrun;
`ifdef PDM_DESER_OVR_CNT_EN
    logic [7:0]    ovr_count;
    logic [7:0]    m_cnt;
`endif

    int total = 0;
    int bad = 0;
    int pat = 0;
    int n;

    // Model state: m_c is the index of the current cycle within the present enabled run.
    int           m_c;
    logic         m_valid;
    logic         m_ovr;
    logic         m_pdm;
    logic [W-1:0] m_d0;
    logic [W-1:0] m_d1;

    pdm_ddr_deserializer #(.N_LINES(NL), .DIV(DIV), .FRAME_BITS(FB)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .ddr_data(ddr_data),
        .pdm_clk_o(pdm_clk_o),
        .out_data_0(out_data_0),
        .out_data_1(out_data_1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun(overrun),
        .ovr_clr(ovr_clr)
`ifdef PDM_DESER_OVR_CNT_EN
        ,
        .ovr_count(ovr_count)
`endif
    );

    always #5 clk = ~clk;

    // Bit a microphone presents: line i, PDM period k of the run, channel ab (0 = A, 1 = B).
    function automatic logic fbit(int i, int k, int ab);
        int h;
        if (pat == 0)
            return (i == 0) ? logic'(ab == 0) : logic'(k % 2);
        h = (k * 29 + i * 13 + ab * 7) ^ (k >> 1);
        return h[2];
    endfunction

    // Expected word of frame m: period m*FB+j lands in bit FB-1-j of each line.
    function automatic logic [W-1:0] word(int m, int ab);
        logic [W-1:0] w = '0;
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < FB; j++)
                w[i*FB + FB-1-j] = fbit(i, m * FB + j, ab);
        return w;
    endfunction

    function automatic logic is_frame();
        return en && ((m_c + 1) % F == 0);
    endfunction

    function automatic logic drop_now();
        return is_frame() && m_valid && !out_ready;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 3 * F) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (!out_valid)
            chk("valid_timeout", out_valid, 1);
    endtask

    // Behavioural model: frames finish every F enabled cycles; handshake and overrun from their rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_c     <= 0;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            m_pdm   <= 1'b0;
            m_d0    <= '0;
            m_d1    <= '0;
`ifdef PDM_DESER_OVR_CNT_EN
            m_cnt   <= 8'd0;
`endif
        end else begin
            if (is_frame() && (!m_valid || out_ready)) begin
                m_d0    <= word((m_c + 1) / F - 1, 0);
                m_d1    <= word((m_c + 1) / F - 1, 1);
                m_valid <= 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
            m_ovr <= drop_now() ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
`ifdef PDM_DESER_OVR_CNT_EN
            m_cnt <= drop_now() ? (ovr_clr ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1))
                                : (ovr_clr ? 8'd0 : m_cnt);
`endif
            m_pdm <= en && (((m_c + 1) % P) < DIV);
            m_c   <= en ? m_c + 1 : 0;
        end
    end

    // Pad driver: channel A during the high half of each period, channel B during the low half.
    initial forever begin
        @(posedge clk or negedge rst);
        #1;
        for (int i = 0; i < NL; i++)
            ddr_data[i] = fbit(i, m_c / P, ((m_c % P) < DIV) ? 0 : 1);
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("pdm_clk_o", pdm_clk_o, m_pdm);
        chk("out_valid", out_valid, m_valid);
        chk("overrun", overrun, m_ovr);
        chk("out_data_0", out_data_0, m_d0);
        chk("out_data_1", out_data_1, m_d1);
`ifdef PDM_DESER_OVR_CNT_EN
        chk("ovr_count", ovr_count, m_cnt);
`endif
    end

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data0", out_data_0, 0);
        chk("rst_pdm", pdm_clk_o, 0);

        // Basic packing with the fixed pattern.
        @(posedge clk);
        #1;
        rst = 1'b1;
        en = 1'b1;
        wait_valid(n);
        chk("lat_first", n, 64);
        chk("basic_d0", out_data_0, 16'h55FF);
        chk("basic_d1", out_data_1, 16'h5500);
        @(posedge clk);
        #1;
        wait_valid(n);
        chk("valid_period", n + 1, 64);
        chk("basic_d0_b", out_data_0, 16'h55FF);
        chk("basic_d1_b", out_data_1, 16'h5500);

        // Reset in the middle of a frame.
        for (int t = 0; t < 2 * F && (m_c / P) % FB != 3; t++) begin
            @(posedge clk);
            #1;
        end
        pat = 1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_d0", out_data_0, 0);
        chk("mid_rst_d1", out_data_1, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_pdm", pdm_clk_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_valid(n);
        chk("lat_after_rst", n, 64);

        // Backpressure: hold one frame, drop the next.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        wait_valid(n);
        repeat (F + F / 2) @(posedge clk);
        #1;
        chk("bp_valid", out_valid, 1);
        chk("bp_overrun", overrun, 1);
`ifdef PDM_DESER_OVR_CNT_EN
        chk("bp_count", ovr_count, 1);
`endif
        ovr_clr = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr = 1'b0;
        chk("clr_overrun", overrun, 0);
        out_ready = 1'b1;

        // Ready asserted exactly on the completion cycle.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        wait_valid(n);
        for (int t = 0; t < 2 * F && (m_c % F) != F - 1; t++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("sc_valid", out_valid, 1);
        chk("sc_overrun", overrun, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Disable partway through a frame, then re-enable.
        for (int t = 0; t < 2 * F && (m_c / P) % FB != 5; t++) begin
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk("dis_pdm", pdm_clk_o, 0);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        wait_valid(n);
        chk("lat_after_en", n, 64);

`ifdef PDM_DESER_OVR_CNT_EN
        // Long stall to drive the counter into saturation.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (302 * F) @(posedge clk);
        #1;
        chk("sat_count", ovr_count, 255);
        out_ready = 1'b1;
`endif

        repeat (10) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
